// File: rtl/decode_queue.sv
// decode_queue: registered RV32I(+M) decoder for the ID stage, holding
// decoded control bundles in a small in-order queue.
module decode_queue #(
    parameter int DEPTH = 2,
    parameter bit EN_M  = 1'b0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        flush,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_instr,
    input  logic [31:0] in_pc,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_pc,
    output logic [31:0] out_imm,
    output logic [4:0]  out_rd,
    output logic [4:0]  out_rs1,
    output logic [4:0]  out_rs2,
    output logic        out_jal,
    output logic        out_jalr,
    output logic        out_mem_to_reg,
    output logic        out_load_npc,
    output logic        out_alu_src1,
    output logic [2:0]  out_reg_write,
    output logic [3:0]  out_mem_write,
    output logic [1:0]  out_reg_read,
    output logic [2:0]  out_branch_type,
    output logic [3:0]  out_alu_ctrl,
    output logic [1:0]  out_alu_src2,
    output logic [2:0]  out_imm_type,
    output logic        out_md_valid,
    output logic [2:0]  out_md_op,
    output logic        out_illegal,
    output logic [15:0] illegal_count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    localparam logic [2:0] NOREGWRITE = 3'd0, LB = 3'd1, LH = 3'd2;
    localparam logic [2:0] LW = 3'd3, LBU = 3'd4, LHU = 3'd5;
    localparam logic [2:0] NOBRANCH = 3'd0, BEQ = 3'd1, BNE = 3'd2;
    localparam logic [2:0] BLT = 3'd3, BLTU = 3'd4, BGE = 3'd5, BGEU = 3'd6;
    localparam logic [2:0] RTYPE = 3'd0, ITYPE = 3'd1, STYPE = 3'd2;
    localparam logic [2:0] BTYPE = 3'd3, UTYPE = 3'd4, JTYPE = 3'd5;
    localparam logic [3:0] SLL = 4'd0, SRL = 4'd1, SRA = 4'd2, ADD = 4'd3;
    localparam logic [3:0] SUB = 4'd4, XOR = 4'd5, OR = 4'd6, AND = 4'd7;
    localparam logic [3:0] SLT = 4'd8, SLTU = 4'd9, ALU_LUI = 4'd10;

    localparam logic [6:0] OPC_LUI = 7'b0110111, OPC_AUIPC = 7'b0010111;
    localparam logic [6:0] OPC_JAL = 7'b1101111, OPC_JALR = 7'b1100111;
    localparam logic [6:0] OPC_BR = 7'b1100011, OPC_LD = 7'b0000011;
    localparam logic [6:0] OPC_ST = 7'b0100011, OPC_OPI = 7'b0010011;
    localparam logic [6:0] OPC_OP = 7'b0110011;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] imm;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic        jal;
        logic        jalr;
        logic        mem_to_reg;
        logic        load_npc;
        logic        alu_src1;
        logic [2:0]  reg_write;
        logic [3:0]  mem_write;
        logic [1:0]  reg_read;
        logic [2:0]  branch_type;
        logic [3:0]  alu_ctrl;
        logic [1:0]  alu_src2;
        logic [2:0]  imm_type;
        logic        md_valid;
        logic [2:0]  md_op;
        logic        illegal;
    } dec_t;

    logic [6:0] opc, f7;
    logic [2:0] f3;
    logic is_lui, is_auipc, is_jal, is_jalr, is_br;
    logic is_ld, is_st, is_opi, is_op;

    assign opc = in_instr[6:0];
    assign f3  = in_instr[14:12];
    assign f7  = in_instr[31:25];

    assign is_lui   = opc == OPC_LUI;
    assign is_auipc = opc == OPC_AUIPC;
    assign is_jal   = opc == OPC_JAL;
    assign is_jalr  = opc == OPC_JALR;
    assign is_br    = opc == OPC_BR;
    assign is_ld    = opc == OPC_LD;
    assign is_st    = opc == OPC_ST;
    assign is_opi   = opc == OPC_OPI;
    assign is_op    = opc == OPC_OP;

    function automatic logic [3:0] alu_f3(input logic [2:0] f,
                                          input logic alt);
        logic [3:0] a;
        unique case (f)
            3'b000:  a = alt ? SUB : ADD;
            3'b001:  a = SLL;
            3'b010:  a = SLT;
            3'b011:  a = SLTU;
            3'b100:  a = XOR;
            3'b101:  a = alt ? SRA : SRL;
            3'b110:  a = OR;
            default: a = AND;
        endcase
        return a;
    endfunction

    dec_t dec;
    logic bad;

    always_comb begin
        dec     = '0;
        bad     = 1'b0;
        dec.pc  = in_pc;
        dec.rd  = in_instr[11:7];
        dec.rs1 = in_instr[19:15];
        dec.rs2 = in_instr[24:20];
        unique case (1'b1)
            is_lui: begin
                dec.alu_ctrl  = ALU_LUI;
                dec.reg_write = LW;
                dec.imm_type  = UTYPE;
                dec.alu_src2  = 2'b10;
            end
            is_auipc: begin
                dec.alu_src1  = 1'b1;
                dec.alu_ctrl  = ADD;
                dec.reg_write = LW;
                dec.imm_type  = UTYPE;
                dec.alu_src2  = 2'b10;
            end
            is_jal: begin
                dec.jal       = 1'b1;
                dec.load_npc  = 1'b1;
                dec.reg_write = LW;
                dec.imm_type  = JTYPE;
                dec.alu_ctrl  = ADD;
                dec.alu_src2  = 2'b10;
            end
            is_jalr: begin
                dec.jalr      = 1'b1;
                dec.load_npc  = 1'b1;
                dec.reg_write = LW;
                dec.imm_type  = ITYPE;
                dec.alu_ctrl  = ADD;
                dec.reg_read  = 2'b10;
                dec.alu_src2  = 2'b10;
                bad           = f3 != 3'b000;
            end
            is_br: begin
                dec.imm_type = BTYPE;
                dec.alu_ctrl = ADD;
                dec.reg_read = 2'b11;
                case (f3)
                    3'b000:  dec.branch_type = BEQ;
                    3'b001:  dec.branch_type = BNE;
                    3'b100:  dec.branch_type = BLT;
                    3'b101:  dec.branch_type = BGE;
                    3'b110:  dec.branch_type = BLTU;
                    3'b111:  dec.branch_type = BGEU;
                    default: bad = 1'b1;
                endcase
            end
            is_ld: begin
                dec.mem_to_reg = 1'b1;
                dec.imm_type   = ITYPE;
                dec.alu_ctrl   = ADD;
                dec.reg_read   = 2'b10;
                dec.alu_src2   = 2'b10;
                case (f3)
                    3'b000:  dec.reg_write = LB;
                    3'b001:  dec.reg_write = LH;
                    3'b010:  dec.reg_write = LW;
                    3'b100:  dec.reg_write = LBU;
                    3'b101:  dec.reg_write = LHU;
                    default: bad = 1'b1;
                endcase
            end
            is_st: begin
                dec.imm_type = STYPE;
                dec.alu_ctrl = ADD;
                dec.reg_read = 2'b11;
                dec.alu_src2 = 2'b10;
                case (f3)
                    3'b000:  dec.mem_write = 4'b0001;
                    3'b001:  dec.mem_write = 4'b0011;
                    3'b010:  dec.mem_write = 4'b1111;
                    default: bad = 1'b1;
                endcase
            end
            is_opi: begin
                dec.imm_type  = ITYPE;
                dec.reg_read  = 2'b10;
                dec.reg_write = LW;
                dec.alu_ctrl  = (f3 == 3'b000) ? ADD : alu_f3(f3, f7[5]);
                if (f3 == 3'b001 || f3 == 3'b101) begin
                    dec.alu_src2 = 2'b01;
                    bad = !(f7 == 7'b0000000 ||
                            (f3 == 3'b101 && f7 == 7'b0100000));
                end else begin
                    dec.alu_src2 = 2'b10;
                end
            end
            is_op: begin
                dec.reg_read  = 2'b11;
                dec.reg_write = LW;
                dec.alu_ctrl  = alu_f3(f3, f7[5]);
                if (f7 == 7'b0000001) begin
                    bad = !EN_M;
                    dec.md_valid = EN_M;
                    dec.md_op    = EN_M ? f3 : 3'b000;
                end else begin
                    bad = !(f7 == 7'b0000000 ||
                            (f7 == 7'b0100000 &&
                             (f3 == 3'b000 || f3 == 3'b101)));
                end
            end
            default: bad = 1'b1;
        endcase

        case (dec.imm_type)
            ITYPE:   dec.imm = {{20{in_instr[31]}}, in_instr[31:20]};
            STYPE:   dec.imm = {{20{in_instr[31]}}, in_instr[31:25],
                                in_instr[11:7]};
            BTYPE:   dec.imm = {{19{in_instr[31]}}, in_instr[31],
                                in_instr[7], in_instr[30:25],
                                in_instr[11:8], 1'b0};
            UTYPE:   dec.imm = {in_instr[31:12], 12'b0};
            JTYPE:   dec.imm = {{11{in_instr[31]}}, in_instr[31],
                                in_instr[19:12], in_instr[20],
                                in_instr[30:21], 1'b0};
            default: dec.imm = '0;
        endcase

        if (dec.rd == 5'd0) dec.reg_write = NOREGWRITE;
        // illegal entries must not cause any architectural side effect
        if (bad) begin
            dec.illegal     = 1'b1;
            dec.reg_write   = NOREGWRITE;
            dec.mem_write   = '0;
            dec.branch_type = NOBRANCH;
            dec.jal         = 1'b0;
            dec.jalr        = 1'b0;
            dec.md_valid    = 1'b0;
        end
    end

    dec_t            mem [DEPTH];
    logic [AW-1:0]   wptr, rptr;
    logic [CW-1:0]   count;
    logic            rdy_en;
    logic            push, pop;
    dec_t            head;

    assign in_ready  = rdy_en && (count < CW'(DEPTH)) && !flush;
    assign out_valid = count != '0;
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;
    assign head      = out_valid ? mem[rptr] : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdy_en <= 1'b0;
        end else begin
            rdy_en <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else if (flush) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (push) wptr <= wptr + 1'b1;
            if (pop)  rptr <= rptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (push) begin
            mem[wptr] <= dec;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            illegal_count <= '0;
        end else if (push && dec.illegal && illegal_count != 16'hFFFF) begin
            illegal_count <= illegal_count + 16'd1;
        end
    end

    assign out_pc          = head.pc;
    assign out_imm         = head.imm;
    assign out_rd          = head.rd;
    assign out_rs1         = head.rs1;
    assign out_rs2         = head.rs2;
    assign out_jal         = head.jal;
    assign out_jalr        = head.jalr;
    assign out_mem_to_reg  = head.mem_to_reg;
    assign out_load_npc    = head.load_npc;
    assign out_alu_src1    = head.alu_src1;
    assign out_reg_write   = head.reg_write;
    assign out_mem_write   = head.mem_write;
    assign out_reg_read    = head.reg_read;
    assign out_branch_type = head.branch_type;
    assign out_alu_ctrl    = head.alu_ctrl;
    assign out_alu_src2    = head.alu_src2;
    assign out_imm_type    = head.imm_type;
    assign out_md_valid    = head.md_valid;
    assign out_md_op       = head.md_op;
    assign out_illegal     = head.illegal;
endmodule
